// File: rtl/sram_responder.sv
// Bus responder for the z80computer system bus, serving each request
// from an external asynchronous SRAM with programmable wait states.
module sram_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int WE_CYCLES   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_dat,
    output logic [7:0]            o_dat,
    input  logic                  i_we,
    input  logic                  i_cs,
    output logic                  o_ack,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [7:0]            o_sram_dq,
    input  logic [7:0]            i_sram_dq,
    output logic                  o_sram_dq_oe,
    output logic                  o_sram_ce_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n
);

    localparam int MAXC = (WAIT_CYCLES > WE_CYCLES) ? WAIT_CYCLES : WE_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] RD_LOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACCESS,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_d;
    logic                    we_q;
    logic                    we_q_d;
    logic [7:0]              dat_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [7:0]              dq_d;
    logic                    dq_oe_d;
    logic                    ce_n_d;
    logic                    oe_n_d;
    logic                    we_n_d;
    logic                    match;
    logic                    start;
    logic                    cnt_zero;

    // A changed address or direction while parked in DONE is a fresh request.
    assign match    = ({i_addr, i_we} == {o_sram_addr, we_q});
    assign start    = i_cs & ((state == IDLE) | ((state == DONE) & ~match));
    assign cnt_zero = (cnt == '0);
    assign o_ack    = (state == DONE) & i_cs & match;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            o_dat        <= 8'h00;
            o_sram_addr  <= '0;
            o_sram_dq    <= 8'h00;
            o_sram_dq_oe <= 1'b0;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            we_q         <= we_q_d;
            o_dat        <= dat_d;
            o_sram_addr  <= addr_d;
            o_sram_dq    <= dq_d;
            o_sram_dq_oe <= dq_oe_d;
            o_sram_ce_n  <= ce_n_d;
            o_sram_oe_n  <= oe_n_d;
            o_sram_we_n  <= we_n_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (i_cs) begin
                    state_d = i_we ? WR_SETUP : RD_ACCESS;
                end
            end
            RD_ACCESS: begin
                if (cnt_zero) begin
                    state_d = DONE;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_zero) begin
                    state_d = WR_HOLD;
                end
            end
            WR_HOLD: begin
                state_d = DONE;
            end
            DONE: begin
                if (!i_cs) begin
                    state_d = IDLE;
                end else if (!match) begin
                    state_d = i_we ? WR_SETUP : RD_ACCESS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register inputs for the next cycle; SRAM pins never see combinational logic.
    always_comb begin
        cnt_d   = cnt;
        we_q_d  = we_q;
        dat_d   = o_dat;
        addr_d  = o_sram_addr;
        dq_d    = o_sram_dq;
        dq_oe_d = o_sram_dq_oe;
        ce_n_d  = o_sram_ce_n;
        oe_n_d  = o_sram_oe_n;
        we_n_d  = o_sram_we_n;
        unique case (1'b1)
            start: begin
                addr_d = i_addr;
                dq_d   = i_dat;
                we_q_d = i_we;
                ce_n_d = 1'b0;
                if (i_we) begin
                    dq_oe_d = 1'b1;
                end else begin
                    oe_n_d = 1'b0;
                    cnt_d  = RD_LOAD;
                end
            end
            (state == RD_ACCESS): begin
                if (cnt_zero) begin
                    dat_d  = i_sram_dq;
                    ce_n_d = 1'b1;
                    oe_n_d = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            (state == WR_SETUP): begin
                we_n_d = 1'b0;
                cnt_d  = WR_LOAD;
            end
            (state == WR_PULSE): begin
                if (cnt_zero) begin
                    we_n_d = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            (state == WR_HOLD): begin
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule
